coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_pkg.sv | 14 +
 rtl/coin_debouncer.sv | 85 ++++++++
 rtl/coin_acceptor.sv | 87 ++++++++
 tb/tb_coin_acceptor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and defaults for the coin acceptor and its per-channel debouncers.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } coin_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF           = 20;

endpackage

// File: rtl/coin_debouncer.sv
// One coin channel: 2-flop synchronizer, press/release debounce FSM and counter.
// qualify_o is a single-cycle event on the edge where a press is accepted as stable.
module coin_debouncer
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sensor_i,
  output logic        qualify_o,
  output coin_state_e state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic              sync1_q;
  logic              sync2_q;
  coin_state_e       state_q;
  coin_state_e       state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only advances below CNT_LAST, so it saturates rather than wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qualify_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          state_d   = HELD;
          qualify_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = HELD;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/coin_acceptor.sv
// Two-channel coin acceptor: debounced 100/500 coin switches, pending flags,
// a 500-first output arbiter and a single-cycle reject pulse for the return gate.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clockFPGA,
  input  logic reset,
  input  logic sensor100,
  input  logic sensor500,
  input  logic aceptar,
  output logic moneda100,
  output logic moneda500,
  output logic rechazo
);

  logic        qual100;
  logic        qual500;
  coin_state_e state100;
  coin_state_e state500;

  logic pend100_q, pend100_d;
  logic pend500_q, pend500_d;
  logic moneda100_q, moneda100_d;
  logic moneda500_q, moneda500_d;
  logic rechazo_q, rechazo_d;

  logic want100;
  logic want500;

  coin_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb100 (
    .clk_i     (clockFPGA),
    .rst_i     (reset),
    .sensor_i  (sensor100),
    .qualify_o (qual100),
    .state_o   (state100)
  );

  coin_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb500 (
    .clk_i     (clockFPGA),
    .rst_i     (reset),
    .sensor_i  (sensor500),
    .qualify_o (qual500),
    .state_o   (state500)
  );

  // A coin qualified this cycle joins the pending set immediately so the pulse
  // lands on the qualifying edge; whatever is not granted stays pending.
  always_comb begin
    want500     = pend500_q | (qual500 & aceptar);
    want100     = pend100_q | (qual100 & aceptar);
    moneda500_d = want500;
    moneda100_d = want100 & ~want500;
    pend500_d   = want500 & ~moneda500_d;
    pend100_d   = want100 & ~moneda100_d;
    rechazo_d   = (qual100 | qual500) & ~aceptar;
  end

  always_ff @(posedge clockFPGA or posedge reset) begin
    if (reset) begin
      pend100_q   <= 1'b0;
      pend500_q   <= 1'b0;
      moneda100_q <= 1'b0;
      moneda500_q <= 1'b0;
      rechazo_q   <= 1'b0;
    end else begin
      pend100_q   <= pend100_d;
      pend500_q   <= pend500_d;
      moneda100_q <= moneda100_d;
      moneda500_q <= moneda500_d;
      rechazo_q   <= rechazo_d;
    end
  end

  assign moneda100 = moneda100_q;
  assign moneda500 = moneda500_q;
  assign rechazo   = rechazo_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4: every output pulse is
// matched against a queue of {cycle, output code} entries pushed when stimulus is driven.
module tb_coin_acceptor;

  localparam int D = 4;
  localparam int LAT = D + 3;
  localparam logic [1:0] C_M100 = 2'd1;
  localparam logic [1:0] C_M500 = 2'd2;
  localparam logic [1:0] C_REJ  = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s100 = 1'b0;
  logic s500 = 1'b0;
  logic acc = 1'b1;
  logic m100;
  logic m500;
  logic rej;

  logic [31:0] cyc = '0;
  logic [31:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .clockFPGA (clk),
    .reset     (rst),
    .sensor100 (s100),
    .sensor500 (s500),
    .aceptar   (acc),
    .moneda100 (m100),
    .moneda500 (m500),
    .rechazo   (rej)
  );

  // clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // drivers
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [1:0] code, input logic [31:0] at);
    exp_q.push_back({at[29:0], code});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m100"}, {31'd0, m100}, 32'd0);
    check({tag, "_m500"}, {31'd0, m500}, 32'd0);
    check({tag, "_rej"},  {31'd0, rej},  32'd0);
  endtask

  task automatic check_drained(input string tag);
    check(tag, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // scoreboard: compare each observed pulse with the oldest expected entry
  task automatic match_pulse(input logic [1:0] code);
    logic [31:0] want;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL unexpected_pulse code=%0d cycle=%0d expected=none", code, cyc);
    end else begin
      want = exp_q.pop_front();
      check("pulse", {cyc[29:0], code}, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m500) match_pulse(C_M500);
      if (m100) match_pulse(C_M100);
      if (rej)  match_pulse(C_REJ);
      if (m100 || m500) check("exclusive", {31'd0, m100 & m500}, 32'd0);
    end
  end

  logic [31:0] c;

  initial begin
    wait_cycles(3);
    check_idle_outputs("in_reset");
    rst = 1'b0;

    // reset asserted mid-debounce discards the coin
    wait_cycles(2);
    s100 = 1'b1;
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(1);
    check_idle_outputs("mid_debounce_reset");
    s100 = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(12);
    check_drained("after_mid_reset");

    // sensor held across reset release: debounced afresh, one event
    s100 = 1'b1;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    c = cyc;
    expect_pulse(C_M100, c + LAT);
    wait_cycles(20);
    s100 = 1'b0;
    wait_cycles(15);
    check_drained("held_across_reset");

    // clean 100 press held 20 cycles
    c = cyc;
    s100 = 1'b1;
    expect_pulse(C_M100, c + LAT);
    wait_cycles(20);
    s100 = 1'b0;
    wait_cycles(15);
    check_drained("press100");

    // bouncing 500 then stable
    s500 = 1'b1; wait_cycles(1);
    s500 = 1'b0; wait_cycles(1);
    s500 = 1'b1; wait_cycles(1);
    s500 = 1'b0; wait_cycles(1);
    c = cyc;
    s500 = 1'b1;
    expect_pulse(C_M500, c + LAT);
    wait_cycles(20);
    s500 = 1'b0;
    wait_cycles(15);
    check_drained("bounce500");

    // simultaneous coins; aceptar drops after qualification
    c = cyc;
    s100 = 1'b1;
    s500 = 1'b1;
    expect_pulse(C_M500, c + LAT);
    expect_pulse(C_M100, c + LAT + 1);
    wait_cycles(LAT);
    acc = 1'b0;
    wait_cycles(20);
    s100 = 1'b0;
    s500 = 1'b0;
    wait_cycles(15);
    acc = 1'b1;
    check_drained("simultaneous");

    // rejected 100, then accepted 100
    acc = 1'b0;
    c = cyc;
    s100 = 1'b1;
    expect_pulse(C_REJ, c + LAT);
    wait_cycles(12);
    s100 = 1'b0;
    wait_cycles(15);
    check_drained("reject100");
    acc = 1'b1;
    c = cyc;
    s100 = 1'b1;
    expect_pulse(C_M100, c + LAT);
    wait_cycles(12);
    s100 = 1'b0;
    wait_cycles(15);
    check_drained("accept_after_reject");

    // both channels rejected together: one reject pulse
    acc = 1'b0;
    c = cyc;
    s100 = 1'b1;
    s500 = 1'b1;
    expect_pulse(C_REJ, c + LAT);
    wait_cycles(12);
    s100 = 1'b0;
    s500 = 1'b0;
    wait_cycles(15);
    acc = 1'b1;
    check_drained("double_reject");

    // 3-cycle glitch: no activity
    s100 = 1'b1;
    wait_cycles(3);
    s100 = 1'b0;
    wait_cycles(15);
    check_drained("glitch3");
    check_idle_outputs("final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
